// File: rtl/usb_command_decoder.sv
// rtl/usb_command_decoder.sv - USB host command word decoder holding the Usb* configuration registers

module usb_command_decoder #(
    parameter int MASK_WORDS = 12
) (
    input  logic                    Clk,
    input  logic                    reset_n,
    input  logic                    CmdFifoEmpty,
    output logic                    CmdFifoRdEn,
    input  logic [15:0]             CmdFifoData,
    output logic [1:0]              ModeSelect,
    output logic [9:0]              UsbMicroroc10BitDac0,
    output logic [9:0]              UsbMicroroc10BitDac1,
    output logic [9:0]              UsbMicroroc10BitDac2,
    output logic [1:0]              SweepAcqDacSelect,
    output logic [16*MASK_WORDS-1:0] UsbMicrorocChannelMask,
    output logic [63:0]             UsbMicrorocCTestChannel,
    output logic                    UsbMicrorocSCParameterLoad,
    output logic                    UsbSCOrReadreg,
    output logic                    UsbMicrorocAcqStartStop,
    output logic                    UsbSweepTestStartStop,
    output logic                    IllegalCmd
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT1, S_DECODE, S_MASK_REQ, S_MASK_WAIT, S_MASK_WR, S_LOAD
    } state_t;

    localparam logic [4:0] MASK_WORDS_L = 5'(MASK_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic        w_rd_en_next;
    logic [3:0]  w_op;
    logic [11:0] w_p;
    logic [4:0]  r_mask_idx;

    assign w_op = CmdFifoData[15:12];
    assign w_p  = CmdFifoData[11:0];

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            CmdFifoRdEn <= 1'b0;
        end else begin
            r_state     <= w_next;
            CmdFifoRdEn <= w_rd_en_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_rd_en_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!CmdFifoEmpty) begin
                    w_next       = S_WAIT1;
                    w_rd_en_next = 1'b1;
                end
            end
            S_WAIT1:  w_next = S_DECODE;
            S_DECODE: begin
                if (w_op == 4'h6)      w_next = S_MASK_REQ;
                else if (w_op == 4'h8) w_next = S_LOAD;
                else                   w_next = S_IDLE;
            end
            S_MASK_REQ: begin
                if (!CmdFifoEmpty) begin
                    w_next       = S_MASK_WAIT;
                    w_rd_en_next = 1'b1;
                end
            end
            S_MASK_WAIT: w_next = S_MASK_WR;
            S_MASK_WR:   w_next = S_IDLE;
            S_LOAD:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // FIFO data is valid in DECODE and MASK_WR, so both consume CmdFifoData directly
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            ModeSelect                 <= 2'b00;
            UsbMicroroc10BitDac0       <= 10'd0;
            UsbMicroroc10BitDac1       <= 10'd0;
            UsbMicroroc10BitDac2       <= 10'd0;
            SweepAcqDacSelect          <= 2'b00;
            UsbMicrorocChannelMask     <= '1;
            UsbMicrorocCTestChannel    <= '0;
            UsbMicrorocSCParameterLoad <= 1'b0;
            UsbSCOrReadreg             <= 1'b0;
            UsbMicrorocAcqStartStop    <= 1'b0;
            UsbSweepTestStartStop      <= 1'b0;
            IllegalCmd                 <= 1'b0;
            r_mask_idx                 <= 5'd0;
        end else begin
            IllegalCmd                 <= 1'b0;
            UsbMicrorocSCParameterLoad <= 1'b0;
            case (r_state)
                S_DECODE: begin
                    case (w_op)
                        4'h1: begin
                            if (UsbMicrorocAcqStartStop || UsbSweepTestStartStop || w_p[1:0] == 2'b11)
                                IllegalCmd <= 1'b1;
                            else
                                ModeSelect <= w_p[1:0];
                        end
                        4'h2: UsbMicroroc10BitDac0 <= w_p[9:0];
                        4'h3: UsbMicroroc10BitDac1 <= w_p[9:0];
                        4'h4: UsbMicroroc10BitDac2 <= w_p[9:0];
                        4'h5: begin
                            if (w_p[1:0] == 2'b11) IllegalCmd <= 1'b1;
                            else                   SweepAcqDacSelect <= w_p[1:0];
                        end
                        4'h6: r_mask_idx <= w_p[4:0];
                        4'h7: UsbMicrorocCTestChannel <= w_p[6] ? 64'd0 : (64'd1 << w_p[5:0]);
                        4'h8: UsbSCOrReadreg <= w_p[0];
                        4'h9: begin
                            if (w_p[0] && UsbSweepTestStartStop) IllegalCmd <= 1'b1;
                            else                                 UsbMicrorocAcqStartStop <= w_p[0];
                        end
                        4'hA: begin
                            if (w_p[0] && UsbMicrorocAcqStartStop) IllegalCmd <= 1'b1;
                            else                                   UsbSweepTestStartStop <= w_p[0];
                        end
                        4'hF: begin
                            ModeSelect              <= 2'b00;
                            UsbMicroroc10BitDac0    <= 10'd0;
                            UsbMicroroc10BitDac1    <= 10'd0;
                            UsbMicroroc10BitDac2    <= 10'd0;
                            SweepAcqDacSelect       <= 2'b00;
                            UsbMicrorocChannelMask  <= '1;
                            UsbMicrorocCTestChannel <= '0;
                            UsbSCOrReadreg          <= 1'b0;
                            UsbMicrorocAcqStartStop <= 1'b0;
                            UsbSweepTestStartStop   <= 1'b0;
                            r_mask_idx              <= 5'd0;
                        end
                        default: IllegalCmd <= 1'b1;
                    endcase
                end
                S_MASK_WR: begin
                    if (r_mask_idx >= MASK_WORDS_L) begin
                        IllegalCmd <= 1'b1;
                    end else begin
                        for (int w = 0; w < MASK_WORDS; w++) begin
                            if (r_mask_idx == 5'(w))
                                UsbMicrorocChannelMask[16*w +: 16] <= CmdFifoData;
                        end
                    end
                end
                S_LOAD: UsbMicrorocSCParameterLoad <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_command_decoder.sv
// tb/tb_usb_command_decoder.sv - directed self-checking bench for usb_command_decoder

module tb_usb_command_decoder;

    logic         Clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         CmdFifoEmpty;
    logic         CmdFifoRdEn;
    logic [15:0]  CmdFifoData = 16'h0000;
    logic [1:0]   ModeSelect;
    logic [9:0]   UsbMicroroc10BitDac0, UsbMicroroc10BitDac1, UsbMicroroc10BitDac2;
    logic [1:0]   SweepAcqDacSelect;
    logic [191:0] UsbMicrorocChannelMask;
    logic [63:0]  UsbMicrorocCTestChannel;
    logic         UsbMicrorocSCParameterLoad, UsbSCOrReadreg;
    logic         UsbMicrorocAcqStartStop, UsbSweepTestStartStop, IllegalCmd;

    usb_command_decoder #(.MASK_WORDS(12)) dut (
        .Clk(Clk), .reset_n(reset_n),
        .CmdFifoEmpty(CmdFifoEmpty), .CmdFifoRdEn(CmdFifoRdEn), .CmdFifoData(CmdFifoData),
        .ModeSelect(ModeSelect),
        .UsbMicroroc10BitDac0(UsbMicroroc10BitDac0),
        .UsbMicroroc10BitDac1(UsbMicroroc10BitDac1),
        .UsbMicroroc10BitDac2(UsbMicroroc10BitDac2),
        .SweepAcqDacSelect(SweepAcqDacSelect),
        .UsbMicrorocChannelMask(UsbMicrorocChannelMask),
        .UsbMicrorocCTestChannel(UsbMicrorocCTestChannel),
        .UsbMicrorocSCParameterLoad(UsbMicrorocSCParameterLoad),
        .UsbSCOrReadreg(UsbSCOrReadreg),
        .UsbMicrorocAcqStartStop(UsbMicrorocAcqStartStop),
        .UsbSweepTestStartStop(UsbSweepTestStartStop),
        .IllegalCmd(IllegalCmd)
    );

    always #5 Clk = ~Clk;

    // FIFO model: data appears the cycle after the pop strobe
    logic [15:0] fifo_mem [0:63];
    logic [5:0]  wr_ptr = 6'd0;
    logic [5:0]  rd_ptr = 6'd0;
    assign CmdFifoEmpty = (wr_ptr == rd_ptr);

    always @(posedge Clk) begin
        if (CmdFifoRdEn) begin
            CmdFifoData <= fifo_mem[rd_ptr];
            rd_ptr      <= rd_ptr + 6'd1;
        end
    end

    int checks = 0;
    int failures = 0;
    int ill_cnt = 0;
    int load_cnt = 0;
    int proto_err = 0;
    logic prev_rden = 1'b0;
    logic prev_ill = 1'b0;
    logic prev_load = 1'b0;

    always @(negedge Clk) begin
        if (CmdFifoRdEn && prev_rden) proto_err++;
        if (IllegalCmd && prev_ill) proto_err++;
        if (UsbMicrorocSCParameterLoad && prev_load) proto_err++;
        if (IllegalCmd) ill_cnt++;
        if (UsbMicrorocSCParameterLoad) load_cnt++;
        prev_rden = CmdFifoRdEn;
        prev_ill  = IllegalCmd;
        prev_load = UsbMicrorocSCParameterLoad;
    end

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    logic [191:0] exp_mask;
    logic [63:0]  exp_ctest;
    int base;
    bit seen;
    logic prev_sc;

    initial begin
        cycles(3);
        check("rst_mode", 192'(ModeSelect), 192'(0));
        check("rst_dacs", 192'({UsbMicroroc10BitDac0, UsbMicroroc10BitDac1, UsbMicroroc10BitDac2}), 192'(0));
        check("rst_mask", UsbMicrorocChannelMask, {192{1'b1}});
        check("rst_ctest", 192'(UsbMicrorocCTestChannel), 192'(0));
        check("rst_bits", 192'({CmdFifoRdEn, UsbMicrorocSCParameterLoad, UsbSCOrReadreg,
                                UsbMicrorocAcqStartStop, UsbSweepTestStartStop, IllegalCmd,
                                SweepAcqDacSelect}), 192'(0));
        reset_n = 1'b1;
        cycles(3);
        check("idle_rden", 192'(CmdFifoRdEn), 192'(0));

        // DAC write latency: update visible 2 cycles after the pop strobe
        push(16'h2123);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge Clk);
            if (CmdFifoRdEn) seen = 1;
        end
        check("dac0_pop_seen", 192'(seen), 192'(1));
        @(negedge Clk);
        check("dac0_before", 192'(UsbMicroroc10BitDac0), 192'(0));
        @(negedge Clk);
        check("dac0_lat2", 192'(UsbMicroroc10BitDac0), 192'(10'h123));
        push(16'h33FF);
        push(16'h4005);
        cycles(10);
        check("dac1", 192'(UsbMicroroc10BitDac1), 192'(10'h3FF));
        check("dac2", 192'(UsbMicroroc10BitDac2), 192'(10'h005));

        // Mask write with the second word delayed
        push(16'h6003);
        cycles(10);
        check("mask_wait", UsbMicrorocChannelMask, {192{1'b1}});
        push(16'hA5A5);
        cycles(6);
        exp_mask = {192{1'b1}};
        exp_mask[63:48] = 16'hA5A5;
        check("mask_slice3", UsbMicrorocChannelMask, exp_mask);
        base = ill_cnt;
        push(16'h600C);
        push(16'h1234);
        cycles(10);
        check("mask_oob", UsbMicrorocChannelMask, exp_mask);
        check("mask_oob_ill", 192'(ill_cnt - base), 192'(1));

        // CTest one-hot then clear
        push(16'h7025);
        cycles(5);
        exp_ctest = 64'd1 << 37;
        check("ctest_37", 192'(UsbMicrorocCTestChannel), 192'(exp_ctest));
        push(16'h7040);
        cycles(5);
        check("ctest_clr", 192'(UsbMicrorocCTestChannel), 192'(0));

        // SC load: select stable one cycle before the pulse
        base = load_cnt;
        push(16'h8001);
        seen = 0;
        prev_sc = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clk);
            if (UsbMicrorocSCParameterLoad) begin
                seen = 1;
                check("sc_sel_before", 192'(prev_sc), 192'(1));
                check("sc_sel_during", 192'(UsbSCOrReadreg), 192'(1));
            end
            prev_sc = UsbSCOrReadreg;
        end
        check("sc_load_seen", 192'(seen), 192'(1));
        cycles(4);
        check("sc_load_count", 192'(load_cnt - base), 192'(1));

        // Run-level interlocks
        base = ill_cnt;
        push(16'h9001);
        cycles(4);
        check("acq_on", 192'(UsbMicrorocAcqStartStop), 192'(1));
        push(16'h1001);
        push(16'hA001);
        push(16'h9000);
        push(16'h1002);
        cycles(16);
        check("acq_off", 192'(UsbMicrorocAcqStartStop), 192'(0));
        check("sweep_rej", 192'(UsbSweepTestStartStop), 192'(0));
        check("mode_sweepacq", 192'(ModeSelect), 192'(2'b10));
        check("run_ill", 192'(ill_cnt - base), 192'(2));

        // Async reset during MASK_WAIT aborts the write
        push(16'h6000);
        push(16'h5000);
        base = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clk);
            if (CmdFifoRdEn) begin
                base++;
                if (base == 2) begin
                    seen = 1;
                    reset_n = 1'b0;
                end
            end
        end
        check("mw_reached", 192'(seen), 192'(1));
        cycles(2);
        reset_n = 1'b1;
        cycles(8);
        check("mw_mask", UsbMicrorocChannelMask, {192{1'b1}});
        check("mw_mode", 192'(ModeSelect), 192'(0));

        base = ill_cnt;
        push(16'hB000);
        cycles(6);
        check("op_b_ill", 192'(ill_cnt - base), 192'(1));
        check("op_b_mask", UsbMicrorocChannelMask, {192{1'b1}});
        check("op_b_dac0", 192'(UsbMicroroc10BitDac0), 192'(0));

        // Soft reset
        push(16'h2155);
        push(16'h3066);
        push(16'h6101);
        push(16'h0F0F);
        push(16'h5002);
        cycles(22);
        check("pre_sr_dac0", 192'(UsbMicroroc10BitDac0), 192'(10'h155));
        check("pre_sr_sel", 192'(SweepAcqDacSelect), 192'(2'b10));
        push(16'hF000);
        cycles(5);
        check("sr_dacs", 192'({UsbMicroroc10BitDac0, UsbMicroroc10BitDac1, UsbMicroroc10BitDac2}), 192'(0));
        check("sr_mask", UsbMicrorocChannelMask, {192{1'b1}});
        check("sr_sel", 192'(SweepAcqDacSelect), 192'(0));
        check("proto", 192'(proto_err), 192'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
